// File: rtl/piso_sb.sv
// piso_sb: wide parallel-in, serial-out shifter feeding the SB serial receiver.
// A word is captured through a load/ready handshake and emitted LSB first,
// one bit per enabled clock, followed by a one-cycle done pulse.
module piso_sb #(
    parameter int unsigned WIDTH = 384,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             dout,
    output logic             dvalid,
    output logic             last,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             done_r;
    logic             done_nx;

    // State register; reset aborts any word in flight without a done pulse.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            cnt    <= cnt_nx;
            done_r <= done_nx;
        end
    end

    // Next-state: capture in IDLE, shift while enabled, clear everything on the final bit.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    shreg_nx = din;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt == LAST_IDX) begin
                        state_nx = IDLE;
                        shreg_nx = '0;
                        cnt_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        shreg_nx = {1'b0, shreg[WIDTH-1:1]};
                        cnt_nx   = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and serial outputs decoded straight from state so they line up with the receiver.
    always_comb begin
        ready  = (state == IDLE);
        dout   = shreg[0];
        dvalid = (state == SHIFT) && en;
        last   = (state == SHIFT) && (cnt == LAST_IDX);
        done   = done_r;
    end

endmodule

// File: tb/tb_piso_sb.sv
// tb_piso_sb: directed and randomized checks of piso_sb against a word/bit-index model.
module tb_piso_sb;

    localparam int unsigned WIDTH = 384;
    localparam int unsigned CNT_W = 9;

    logic             clk;
    logic             res;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             dout;
    logic             dvalid;
    logic             last;
    logic             done;

    piso_sb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .res    (res),
        .en     (en),
        .load   (load),
        .din    (din),
        .ready  (ready),
        .dout   (dout),
        .dvalid (dvalid),
        .last   (last),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the word in flight and the index of the bit currently presented.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    int               m_idx  = 0;
    logic [WIDTH-1:0] m_word = '0;

    // Loopback receiver: collects bits the consumer would sample.
    logic [WIDTH-1:0] rx_bits = '0;
    logic [WIDTH-1:0] rx_word = '0;
    int               rx_n    = 0;
    int               edges   = 0;
    int               firstbit_edge = 0;
    int               lastbit_edge  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model across the rising edge.
    task automatic cycle(input logic l, input logic e, input logic [WIDTH-1:0] d);
        load = l;
        en   = e;
        din  = d;
        #1;
        chk("ready",  32'(ready),  32'(!m_busy));
        chk("dout",   32'(dout),   32'(m_busy ? m_word[m_idx] : 1'b0));
        chk("dvalid", 32'(dvalid), 32'(m_busy && e));
        chk("last",   32'(last),   32'(m_busy && (m_idx == WIDTH - 1)));
        chk("done",   32'(done),   32'(m_done));
        if (dvalid && rx_n < WIDTH) begin
            if (rx_n == 0) firstbit_edge = edges + 1;
            if (last) lastbit_edge = edges + 1;
            rx_bits[rx_n] = dout;
            rx_n++;
        end
        @(posedge clk);
        edges++;
        m_done = 1'b0;
        if (!res) begin
            m_busy = 1'b0;
            rx_n   = 0;
        end else if (!m_busy) begin
            if (l) begin
                m_word = d;
                m_idx  = 0;
                m_busy = 1'b1;
                rx_n   = 0;
                rx_bits = '0;
            end
        end else if (e) begin
            if (m_idx == WIDTH - 1) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                rx_word = rx_bits;
                chk_w("loopback", rx_word, m_word);
                rx_n    = 0;
            end else begin
                m_idx++;
            end
        end
        @(negedge clk);
    endtask

    // Send one word; stall_len disabled cycles while bit stall_at is presented,
    // optional junk load at cycle junk_at, optional random enable.
    task automatic send(input logic [WIDTH-1:0] w, input int stall_at, input int stall_len,
                        input int junk_at, input bit rnd_en, input bit chk_gap);
        int   k;
        int   st;
        int   stalled;
        int   prev_last;
        logic e;
        logic l;
        prev_last = lastbit_edge;
        cycle(1'b1, 1'b1, w);
        k       = edges;
        st      = 0;
        stalled = 0;
        for (int n = 0; n < 4 * WIDTH; n++) begin
            if (done) break;
            e = 1'b1;
            if (rnd_en) e = ($urandom_range(3) != 0);
            if (m_busy && m_idx == stall_at && st < stall_len) begin
                e = 1'b0;
                st++;
            end
            if (m_busy && !e) stalled++;
            l = (n == junk_at);
            cycle(l, e, l ? {WIDTH{1'b1}} : '0);
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(edges - k), 32'(WIDTH + stalled));
        if (chk_gap) chk("b2b_gap", 32'(firstbit_edge - prev_last), 32'd2);
    endtask

    logic [WIDTH-1:0] w2;
    logic [WIDTH-1:0] wr;

    initial begin
        res  = 1'b0;
        en   = 1'b1;
        load = 1'b1;
        din  = {WIDTH{1'b1}};
        @(negedge clk);

        // Reset held with a load pending: nothing may be captured.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, {WIDTH{1'b1}});
        res = 1'b1;
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);

        // Single word with recognisable ends.
        for (int i = 0; i < WIDTH / 32; i++) w2[i*32 +: 32] = $urandom;
        w2[15:0]             = 16'h66E2;
        w2[WIDTH-1:WIDTH-16] = 16'h3A7B;
        send(w2, -1, 0, -1, 1'b0, 1'b0);
        chk("first4", 32'(rx_word[3:0]), 32'h2);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, '0);

        // Stall while bit 1 (a zero) is presented.
        send(WIDTH'(5), 1, 5, -1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, '0);

        // Load pulsed mid-word must be ignored.
        send(w2, -1, 0, 50, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, '0);

        // Back-to-back: B loaded in A's done cycle.
        send(WIDTH'(1), -1, 0, -1, 1'b0, 1'b0);
        send(WIDTH'(2), -1, 0, -1, 1'b0, 1'b1);
        chk("b_word", 32'(rx_word[31:0]), 32'h2);
        cycle(1'b0, 1'b1, '0);

        // Reset at bit 100 aborts the word.
        cycle(1'b1, 1'b1, w2);
        for (int i = 0; i < 2 * WIDTH && m_idx < 100; i++) cycle(1'b0, 1'b1, '0);
        chk("at_bit100", 32'(m_idx), 32'd100);
        res = 1'b0;
        #1;
        m_busy = 1'b0;
        rx_n   = 0;
        chk("rst_ready",  32'(ready),  32'd1);
        chk("rst_dout",   32'(dout),   32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_done",   32'(done),   32'd0);
        @(negedge clk);
        cycle(1'b0, 1'b1, '0);
        res = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < WIDTH / 32; i++) wr[i*32 +: 32] = $urandom;
        send(wr, -1, 0, -1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, '0);

        // Random words with random enable gaps.
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < WIDTH / 32; i++) wr[i*32 +: 32] = $urandom;
            send(wr, -1, 0, int'($urandom_range(WIDTH - 1)), 1'b1, 1'b0);
            for (int i = 0; i < int'($urandom_range(2)); i++) cycle(1'b0, 1'($urandom), '0);
        end
        cycle(1'b0, 1'b1, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
